pc_fetch_sequencer: RTL

Multi-cycle fetch/execute sequencer that owns the program counter and drives next-PC selection for the LEGv8 datapath. Fetches each instruction from instruction memory over a req/ack handshake and presents it to the datapath for one execute cycle. It then samples the branch controls and commits either PC+4 or PC+(imm<<2). It replaces the free-running PC register so instruction memory with variable latency can be used.

---
 rtl/pc_fetch_sequencer_pkg.sv | 15 +
 rtl/pc_fetch_sequencer_if.sv | 26 ++
 rtl/pc_fetch_sequencer_next_pc_calc.sv | 23 ++
 rtl/pc_fetch_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pc_fetch_sequencer_pkg.sv
// rtl/pc_fetch_sequencer_pkg.sv - shared types and constants for the LEGv8 fetch sequencer
package pc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      EXEC = 2'd2,
      HALT = 2'd3
   } seq_state_t;

   localparam int unsigned PC_INCR      = 4;
   localparam int unsigned BRANCH_SHIFT = 2;
   localparam int unsigned INSTR_W_DEF  = 32;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - instruction memory req/ack fetch interface
interface pc_fetch_sequencer_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
) ();

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// rtl/pc_fetch_sequencer_next_pc_calc.sv - branch-taken decision and next-PC select
module next_pc_calc
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 64
) (
   input  logic [ADDR_W-1:0] CurrentPC,
   input  logic [ADDR_W-1:0] SignExtImm64,
   input  logic              Branch,
   input  logic              ALUZero,
   input  logic              Uncondbranch,
   output logic [ADDR_W-1:0] NextPC,
   output logic              taken
);

   logic [ADDR_W-1:0] branch_offset;

   // Offset bits shifted past the top are dropped; the add wraps modulo 2^ADDR_W.
   assign branch_offset = SignExtImm64 << BRANCH_SHIFT;
   assign taken         = (Branch & ALUZero) | Uncondbranch;
   assign NextPC        = CurrentPC + (taken ? branch_offset : ADDR_W'(PC_INCR));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - IDLE/REQ/EXEC/HALT fetch sequencer owning the PC; BRANCH_STATS_EN adds counters
module pc_fetch_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          ADDR_W   = 64,
   parameter int          INSTR_W  = INSTR_W_DEF
) (
   input  logic                CLK,
   input  logic                Reset,
   input  logic                start,
   pc_fetch_sequencer_if.master imem,
   output logic [INSTR_W-1:0]  Instruction,
   output logic                exec_valid,
   input  logic                Branch,
   input  logic                ALUZero,
   input  logic                Uncondbranch,
   input  logic [ADDR_W-1:0]   SignExtImm64,
   input  logic                halt,
   output logic [ADDR_W-1:0]   CurrentPC,
   output logic                halted
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]         taken_count,
   output logic [31:0]         instr_count
`endif
);

   seq_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               req_q, req_d;
   logic               exec_q, exec_d;
   logic               halted_q, halted_d;
   logic [ADDR_W-1:0]  next_pc;
   logic               taken;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .CurrentPC    (pc_q),
      .SignExtImm64 (SignExtImm64),
      .Branch       (Branch),
      .ALUZero      (ALUZero),
      .Uncondbranch (Uncondbranch),
      .NextPC       (next_pc),
      .taken        (taken)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = REQ;
         REQ:     if (imem.imem_ack) state_d = EXEC;
         EXEC:    state_d = halt ? HALT : REQ;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Every output is a register; this block computes their next values so
   // imem_req/exec_valid/halted line up with the state they belong to.
   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      req_d    = 1'b0;
      exec_d   = 1'b0;
      halted_d = 1'b0;
      case (state_q)
         IDLE: req_d = start;
         REQ: begin
            if (imem.imem_ack) begin
               instr_d = imem.imem_rdata;
               exec_d  = 1'b1;
            end else begin
               req_d = 1'b1;
            end
         end
         EXEC: begin
            if (halt) begin
               halted_d = 1'b1;
            end else begin
               pc_d  = next_pc;
               req_d = 1'b1;
            end
         end
         HALT:    halted_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_q     <= RESET_PC[ADDR_W-1:0];
         instr_q  <= '0;
         req_q    <= 1'b0;
         exec_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         req_q    <= req_d;
         exec_q   <= exec_d;
         halted_q <= halted_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign Instruction    = instr_q;
   assign exec_valid     = exec_q;
   assign CurrentPC      = pc_q;
   assign halted         = halted_q;

`ifdef BRANCH_STATS_EN
   logic [31:0] taken_cnt_q;
   logic [31:0] instr_cnt_q;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         taken_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else if (state_q == EXEC && !halt) begin
         if (instr_cnt_q != 32'hFFFF_FFFF) instr_cnt_q <= instr_cnt_q + 32'd1;
         if (taken && taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_q <= taken_cnt_q + 32'd1;
      end
   end

   assign taken_count = taken_cnt_q;
   assign instr_count = instr_cnt_q;
`else
   logic unused_taken;
   assign unused_taken = taken;
`endif

endmodule
